// File: rtl/block_pkg.sv
// Shared definitions for the edge-counter block.
// Contents:
//   BLOCK_WIDTH_DEF  default width of the edge count
//   BLOCK_SYNC_DEF   default synchroniser depth
//   count_t          edge-count type at the default width
//   prime_bits()     width of a counter that must reach stages+1
`timescale 1ns / 1ps
package block_pkg;

  localparam int unsigned BLOCK_WIDTH_DEF = 4;
  localparam int unsigned BLOCK_SYNC_DEF  = 2;

  typedef logic [BLOCK_WIDTH_DEF-1:0] count_t;

  // Bits needed to hold the values 0 .. stages+1.
  function automatic int unsigned prime_bits(int unsigned stages);
    return $clog2(stages + 2);
  endfunction

endpackage

// File: rtl/block_if.sv
// Signal bundle between the edge counter and its environment.
// Signals:
//   in_a  asynchronous level input being monitored
//   res   registered edge count, modulo 2**WIDTH
// Modports:
//   master  environment side (drives in_a, observes res)
//   slave   counter side (observes in_a, drives res)
`timescale 1ns / 1ps
interface block_if
  import block_pkg::*;
#(
  parameter int unsigned WIDTH = BLOCK_WIDTH_DEF
);

  logic             in_a;
  logic [WIDTH-1:0] res;

  modport master (output in_a, input res);
  modport slave (input in_a, output res);

endinterface

// File: rtl/block_sync.sv
// Multi-flop synchroniser for a single asynchronous bit.
// Ports:
//   clock    sampling clock
//   reset_n  asynchronous active-low reset, clears every stage
//   d        asynchronous input bit
//   q        synchronised output (last stage)
`timescale 1ns / 1ps
module block_sync
  import block_pkg::*;
#(
  parameter int unsigned STAGES = BLOCK_SYNC_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d};
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/block_core.sv
// Edge counter / activity monitor for slow asynchronous strobes.
// Synchronises bus.in_a, detects rising edges once primed after reset, and
// keeps a wrap-around count on bus.res.
// Ports:
//   clock    single clock, all state updates on its rising edge
//   reset_n  asynchronous active-low reset
//   bus      block_if.slave: in_a (async level in), res (count out)
// Build option:
//   BLOCK_BOTH_EDGES_EN  when defined, falling edges are counted as well
`timescale 1ns / 1ps
module block_core
  import block_pkg::*;
#(
  parameter int unsigned WIDTH       = BLOCK_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = BLOCK_SYNC_DEF
) (
  input logic   clock,
  input logic   reset_n,
  block_if.slave bus
);

  localparam int unsigned      PrimeW    = prime_bits(SYNC_STAGES);
  localparam logic [PrimeW-1:0] PrimeDone = PrimeW'(SYNC_STAGES + 1);

  logic             sync_q;
  logic             prev_q;
  logic [PrimeW-1:0] prime_q, prime_d;
  logic             primed;
  logic             rise;
  logic             cnt_en;
  logic [WIDTH-1:0] res_q, res_d;

  block_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .d      (bus.in_a),
    .q      (sync_q)
  );

  // Edges are ignored until the synchroniser and prev_q hold post-reset
  // samples, so a level already high at reset release is never counted.
  assign primed = (prime_q == PrimeDone);
  assign rise   = primed & sync_q & ~prev_q;

`ifdef BLOCK_BOTH_EDGES_EN
  logic fall;
  assign fall   = primed & ~sync_q & prev_q;
  assign cnt_en = rise | fall;
`else
  assign cnt_en = rise;
`endif

  always_comb begin
    prime_d = prime_q;
    res_d   = res_q;
    if (!primed) begin
      prime_d = prime_q + PrimeW'(1);
    end
    if (cnt_en) begin
      res_d = res_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= 1'b0;
      prime_q <= '0;
      res_q   <= '0;
    end else begin
      prev_q  <= sync_q;
      prime_q <= prime_d;
      res_q   <= res_d;
    end
  end

  assign bus.res = res_q;

endmodule

// File: tb/tb_block_core.sv
`timescale 1ns / 1ps
module tb_block_core;
  import block_pkg::*;

`ifdef BLOCK_BOTH_EDGES_EN
  localparam int unsigned F = 1;  // falling edges also count
`else
  localparam int unsigned F = 0;
`endif

  typedef struct {
    logic        in_a;
    int unsigned hold;
    int unsigned rises;
    int unsigned falls;
  } vec_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  vec_t vecs[9];

  block_if #(.WIDTH(4)) bus ();

  block_core #(
    .WIDTH      (4),
    .SYNC_STAGES(2)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #1 clock = ~clock;

  function automatic int unsigned e(int unsigned r, int unsigned f);
    return (r + F * f) % 16;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string name, input int unsigned exp);
    count_t want;
    want = count_t'(exp);
    checks++;
    if (bus.res !== want) begin
      errors++;
      $display("FAIL %s: res=%0d required %0d (t=%0t)", name, bus.res, want, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    step(1);
    check("reset_clear", 0);
    reset_n = 1'b1;
    step(5);
  endtask

  task automatic pulse();
    bus.in_a = 1'b1;
    step(3);
    bus.in_a = 1'b0;
    step(3);
  endtask

  initial begin
    // in_a, hold cycles, cumulative rises, cumulative falls after the hold
    vecs[0] = '{1'b1, 3, 2, 2};
    vecs[1] = '{1'b0, 3, 2, 3};
    vecs[2] = '{1'b1, 2, 2, 3};  // rise seen by sync, count not yet updated
    vecs[3] = '{1'b1, 2, 3, 3};
    vecs[4] = '{1'b0, 4, 3, 4};
    vecs[5] = '{1'b1, 6, 4, 4};
    vecs[6] = '{1'b0, 3, 4, 5};
    vecs[7] = '{1'b1, 3, 5, 5};
    vecs[8] = '{1'b0, 3, 5, 6};

    // Reset with in_a already high; priming must hide that level.
    reset_n  = 1'b0;
    bus.in_a = 1'b1;
    step(1);
    check("reset_state", 0);
    step(1);
    reset_n = 1'b1;
    step(20);
    check("prime_suppress", 0);

    // Latency of a single rising edge.
    bus.in_a = 1'b0;
    step(3);
    check("first_low", e(0, 1));
    bus.in_a = 1'b1;
    step(1);
    check("lat_k", e(0, 1));
    step(1);
    check("lat_k1", e(0, 1));
    step(1);
    check("lat_k2", e(1, 1));
    step(2);
    check("lat_hold", e(1, 1));
    bus.in_a = 1'b0;
    step(3);
    check("lat_fall", e(1, 2));

    // Table-driven levels and hold times.
    foreach (vecs[i]) begin
      bus.in_a = vecs[i].in_a;
      step(int'(vecs[i].hold));
      check($sformatf("vec%0d", i), e(vecs[i].rises, vecs[i].falls));
    end

    // Toggle every 5 units for 100 units, offset away from clock edges.
    #0.5;
    for (int i = 0; i < 20; i++) begin
      #5 bus.in_a = ~bus.in_a;
    end
    @(negedge clock);
    step(4);
    check("toggle_100", e(15, 16));

    // 17 pulses from a fresh reset: 1..15, 0, 1 (doubled with both edges).
    do_reset();
    for (int i = 0; i < 17; i++) begin
      pulse();
      check($sformatf("wrap%0d", i), ((i + 1) * (1 + F)) % 16);
    end

    // Asynchronous reset in the middle of counting.
    do_reset();
    for (int i = 0; i < 6 / (1 + F); i++) pulse();
    check("pre_reset_6", 6);
    reset_n = 1'b0;
    #0.5;
    check("async_clear", 0);
    @(negedge clock);
    reset_n = 1'b1;
    step(5);
    bus.in_a = 1'b1;
    step(3);
    check("after_reprime_rise", 1);
    bus.in_a = 1'b0;
    step(3);
    check("after_reprime_fall", 1 + F);

`ifdef BLOCK_BOTH_EDGES_EN
    // Three full pulses; the last fall lands two clocks after being sampled.
    do_reset();
    pulse();
    pulse();
    check("both_two_pulses", 4);
    bus.in_a = 1'b1;
    step(3);
    check("both_third_rise", 5);
    bus.in_a = 1'b0;
    step(1);
    check("both_fall_k", 5);
    step(1);
    check("both_fall_k1", 5);
    step(1);
    check("both_fall_k2", 6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
